// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller: state encoding and default sizes.
package mux_scan_ctrl_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NSRC  = 8;
    localparam int SEL_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        VALID = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_ctrl_next_sel.sv
// Combinational next-source finder: lowest set mask bit, either from bit 0
// (first) or strictly above the current index.
module next_sel (
    input  logic [7:0] mask,
    input  logic [2:0] cur,
    input  logic       first,
    output logic [2:0] nxt,
    output logic       found
);

    logic [7:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cand
            assign cand[gi] = mask[gi] & (first | (3'(gi) > cur));
        end
    endgenerate

    // Descending walk so the lowest candidate is the last one written.
    always_comb begin
        nxt   = 3'd0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) begin
                nxt   = 3'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled inputs of an external 8:1 mux in ascending order and
// presents each settled result through a valid/ready output register.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = DEF_NSRC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       mask,
    input  logic [WIDTH-1:0] muxo,
    output logic [2:0]       s,
    output logic [WIDTH-1:0] dout,
    output logic [2:0]       didx,
    output logic             dvalid,
    input  logic             dready,
    output logic             busy,
    output logic             done
);

    // Sources at or above NSRC are never visited.
    localparam logic [7:0] SRC_MASK = 8'((1 << NSRC) - 1);

    state_t           state_reg, state_next;
    logic [2:0]       s_reg, s_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic [2:0]       didx_reg, didx_next;
    logic             done_reg, done_next;
    logic [7:0]       mask_reg, mask_next;

    logic [7:0]       srch_mask;
    logic             srch_first;
    logic [2:0]       srch_nxt;
    logic             srch_found;

    // In IDLE the search looks at the live mask so S can be loaded on the START edge.
    assign srch_first = (state_reg == IDLE);
    assign srch_mask  = srch_first ? (mask & SRC_MASK) : mask_reg;

    next_sel u_next_sel (
        .mask  (srch_mask),
        .cur   (s_reg),
        .first (srch_first),
        .nxt   (srch_nxt),
        .found (srch_found)
    );

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        dout_next  = dout_reg;
        didx_next  = didx_reg;
        mask_next  = mask_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mask_next = mask & SRC_MASK;
                    if (srch_found) begin
                        s_next     = srch_nxt;
                        state_next = SEL;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            SEL: begin
                dout_next  = muxo;
                didx_next  = s_reg;
                state_next = VALID;
            end
            VALID: begin
                if (dready) begin
                    if (srch_found) begin
                        s_next     = srch_nxt;
                        state_next = SEL;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            s_reg     <= 3'd0;
            dout_reg  <= '0;
            didx_reg  <= 3'd0;
            done_reg  <= 1'b0;
            mask_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            dout_reg  <= dout_next;
            didx_reg  <= didx_next;
            done_reg  <= done_next;
            mask_reg  <= mask_next;
        end
    end

    assign s      = s_reg;
    assign dout   = dout_reg;
    assign didx   = didx_reg;
    assign dvalid = (state_reg == VALID);
    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: queue-based scan model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_mux_scan_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst, start, dready;
    logic [7:0]       mask;
    logic [WIDTH-1:0] muxo;
    logic [2:0]       s, didx;
    logic [WIDTH-1:0] dout;
    logic             dvalid, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model state
    int               m_q[$];
    logic [2:0]       m_s     = 3'd0;
    logic [WIDTH-1:0] m_dout  = '0;
    logic [2:0]       m_didx  = 3'd0;
    bit               m_busy  = 1'b0;
    bit               m_valid = 1'b0;
    bit               m_done  = 1'b0;
    bit               m_settle = 1'b0;

    // Handshake log taken from the DUT side
    int hs_idx[$];
    int hs_dout[$];
    int hs_cyc[$];
    int done_cyc;

    mux_scan_ctrl #(.WIDTH(WIDTH), .NSRC(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mask   (mask),
        .muxo   (muxo),
        .s      (s),
        .dout   (dout),
        .didx   (didx),
        .dvalid (dvalid),
        .dready (dready),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Downstream mux: inputs A..H carry their own index.
    function automatic logic [WIDTH-1:0] mux_src(input logic [2:0] i);
        return WIDTH'(i);
    endfunction

    // External mux: correct data while settling, junk otherwise.
    always @(negedge clk) begin
        if (busy && !dvalid) muxo = mux_src(s);
        else                 muxo = WIDTH'($urandom);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_s = 3'd0; m_dout = '0; m_didx = 3'd0;
            m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_settle = 1'b0;
        end else begin
            cyc++;
            if (dvalid && dready) begin
                hs_idx.push_back(int'(didx));
                hs_dout.push_back(int'(dout));
                hs_cyc.push_back(cyc);
            end
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    for (int i = 0; i < 8; i++) if (mask[i]) m_q.push_back(i);
                    if (m_q.size() == 0) m_done = 1'b1;
                    else begin
                        m_s = 3'(m_q.pop_front());
                        m_busy = 1'b1;
                        m_settle = 1'b1;
                    end
                end
            end else if (m_settle) begin
                m_dout = mux_src(m_s);
                m_didx = m_s;
                m_settle = 1'b0;
                m_valid = 1'b1;
            end else if (dready) begin
                m_valid = 1'b0;
                if (m_q.size() > 0) begin
                    m_s = 3'(m_q.pop_front());
                    m_settle = 1'b1;
                end else begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if ({s, dout, didx, dvalid, busy, done} !== {m_s, m_dout, m_didx, m_valid, m_busy, m_done}
                || (done && dvalid)) begin
                n_bad++;
                $display("FAIL cycle %0d: s=%0d/%0d dout=%h/%h didx=%0d/%0d dvalid=%b/%b busy=%b/%b done=%b/%b (got/expected)",
                         cyc, s, m_s, dout, m_dout, didx, m_didx, dvalid, m_valid, busy, m_busy, done, m_done);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        hs_idx.delete(); hs_dout.delete(); hs_cyc.delete();
    endtask

    task automatic pulse_start(input logic [7:0] m);
        mask  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(done), 1);
        done_cyc = cyc;
    endtask

    initial begin
        int k;
        int exp_idx[3];
        rst = 1'b1; start = 1'b0; mask = 8'h00; dready = 1'b1; muxo = '0;
        repeat (2) @(negedge clk);
        check("rst_s", int'(s), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_flags", int'({dvalid, busy, done}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full mask, always ready; mask changes right after the latch edge
        clear_log();
        pulse_start(8'hFF);
        mask = 8'h01;
        k = 1;
        while (!dvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("first_valid_latency", k, 2);
        wait_done(60, "ff_done_timeout");
        check("ff_count", hs_idx.size(), 8);
        for (int i = 0; i < hs_idx.size() && i < 8; i++) begin
            check($sformatf("ff_idx%0d", i), hs_idx[i], i);
            check($sformatf("ff_dout%0d", i), hs_dout[i], i);
            if (i > 0) check($sformatf("ff_spacing%0d", i), hs_cyc[i] - hs_cyc[i-1], 2);
        end
        if (hs_cyc.size() == 8) check("ff_done_after_last", done_cyc, hs_cyc[7]);

        // Sparse mask, with START and MASK poked while busy
        @(negedge clk);
        clear_log();
        pulse_start(8'b1010_0100);
        @(negedge clk);
        mask = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mask = 8'h03;
        wait_done(60, "sparse_done_timeout");
        exp_idx = '{2, 5, 7};
        check("sparse_count", hs_idx.size(), 3);
        for (int i = 0; i < hs_idx.size() && i < 3; i++) begin
            check($sformatf("sparse_idx%0d", i), hs_idx[i], exp_idx[i]);
            check($sformatf("sparse_dout%0d", i), hs_dout[i], exp_idx[i]);
        end
        repeat (3) @(negedge clk);
        check("sparse_no_restart", int'(busy), 0);

        // Consumer stalls 5 cycles on the first item
        clear_log();
        dready = 1'b0;
        pulse_start(8'hFF);
        k = 0;
        while (!dvalid && k < 10) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_dvalid%0d", i), int'(dvalid), 1);
            check($sformatf("stall_dout%0d", i), int'(dout), 0);
            @(negedge clk);
        end
        dready = 1'b1;
        wait_done(60, "stall_done_timeout");
        check("stall_count", hs_idx.size(), 8);
        if (hs_idx.size() > 1) check("stall_resume_idx", hs_idx[1], 1);

        // Empty mask
        @(negedge clk);
        pulse_start(8'h00);
        check("empty_done", int'(done), 1);
        check("empty_busy_valid", int'({busy, dvalid}), 0);
        @(negedge clk);
        check("empty_done_single", int'(done), 0);

        // Reset while presenting index 3
        pulse_start(8'hFF);
        k = 0;
        while (!(dvalid && didx == 3'd3) && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("reach_idx3", int'(didx), 3);
        dready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_s", int'(s), 0);
        check("arst_dout", int'(dout), 0);
        check("arst_flags", int'({didx, dvalid, busy, done}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("arst_no_done", int'(done), 0);
        end
        clear_log();
        dready = 1'b1;
        pulse_start(8'h80);
        wait_done(20, "after_rst_done_timeout");
        check("after_rst_count", hs_idx.size(), 1);
        if (hs_idx.size() > 0) begin
            check("after_rst_idx", hs_idx[0], 7);
            check("after_rst_dout", hs_dout[0], 7);
        end

        // Randomized traffic, occasional asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start  = ($urandom % 4 == 0);
            mask   = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
            dready = ($urandom % 3 != 0);
            if ($urandom % 500 == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
